plot_port_arbiter: RTL

//  - Shares the single VGA adapter write port (x, y, colour, plot) among N_REQ drawing engines:

---
 rtl/draw_arb_pkg.sv | 18 +
 rtl/plot_port_arbiter_if.sv | 21 ++
 rtl/rr_priority_pick.sv | 26 ++
 rtl/plot_port_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the VGA plot-port arbiter slice.
package draw_arb_pkg;

  localparam int unsigned XW_DEF        = 8;
  localparam int unsigned YW_DEF        = 7;
  localparam int unsigned CW_DEF        = 3;
  localparam int unsigned SCREEN_WIDTH  = 160;
  localparam int unsigned SCREEN_HEIGHT = 120;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/plot_port_arbiter_if.sv
// Requester-side bundle: drawing engines (master) to plot arbiter (slave).
interface plot_port_arbiter_if
  import draw_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned XW    = XW_DEF,
  parameter int unsigned YW    = YW_DEF,
  parameter int unsigned CW    = CW_DEF
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ*XW-1:0] req_x;
  logic [N_REQ*YW-1:0] req_y;
  logic [N_REQ*CW-1:0] req_color;
  logic [N_REQ-1:0]    gnt;

  modport master (output req, req_last, req_x, req_y, req_color, input gnt);
  modport slave  (input req, req_last, req_x, req_y, req_color, output gnt);

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set req above rr_ptr, wrapping.
module rr_priority_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [PW-1:0]    winner,
  output logic             any_req
);

  // Scan from farthest to nearest so the nearest set bit above rr_ptr wins.
  always_comb begin
    int          idx;
    logic [PW-1:0] idx_w;
    winner  = '0;
    any_req = |req;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      idx_w = PW'(idx);
      if (req[idx_w]) winner = idx_w;
    end
  end

endmodule

// File: rtl/plot_port_arbiter.sv
// Burst-locked arbiter sharing the VGA adapter write port among drawing engines.
// Build option: define PLOT_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// instead of round-robin between bursts.
module plot_port_arbiter
  import draw_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned XW          = XW_DEF,
  parameter int unsigned YW          = YW_DEF,
  parameter int unsigned CW          = CW_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  plot_port_arbiter_if.slave   bus,
  output logic [XW-1:0]        VGA_X,
  output logic [YW-1:0]        VGA_Y,
  output logic [CW-1:0]        color_to_display,
  output logic                 plot,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int unsigned PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    pick_ptr;
  logic [PW-1:0]    winner;
  logic             any_req;
  logic [WDW-1:0]   watchdog;
  logic [N_REQ-1:0] gnt_q;
  logic             xfer;
  logic             last;
  logic             wd_expired;

`ifdef PLOT_ARB_FIXED_PRIO_EN
  // Pointer parked at the top index makes the picker a plain lowest-index search.
  assign pick_ptr = PW'(N_REQ - 1);
`else
  assign pick_ptr = rr_ptr;
`endif

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (bus.req),
    .rr_ptr  (pick_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Handshake qualifiers for the current holder only; others are ignored.
  assign xfer       = bus.req[owner];
  assign last       = bus.req_last[owner];
  assign wd_expired = (watchdog == WDW'(TIMEOUT_CYC - 1));

  assign bus.gnt = gnt_q;
  assign busy    = (state == ST_GRANT);

  // Arbitration FSM, grant register, watchdog and pixel output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      rr_ptr           <= PW'(N_REQ - 1);
      owner            <= '0;
      gnt_q            <= '0;
      watchdog         <= '0;
      VGA_X            <= '0;
      VGA_Y            <= '0;
      color_to_display <= '0;
      plot             <= 1'b0;
      timeout_pulse    <= 1'b0;
    end else begin
      plot          <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_GRANT;
            owner    <= winner;
            rr_ptr   <= winner;
            gnt_q    <= N_REQ'(1) << winner;
            watchdog <= '0;
          end
        end
        ST_GRANT: begin
          if (xfer) begin
            VGA_X            <= bus.req_x[int'(owner)*XW +: XW];
            VGA_Y            <= bus.req_y[int'(owner)*YW +: YW];
            color_to_display <= bus.req_color[int'(owner)*CW +: CW];
            plot             <= 1'b1;
          end
          if (!xfer || last) begin
            state <= ST_IDLE;
            gnt_q <= '0;
          end else if (wd_expired) begin
            state         <= ST_IDLE;
            gnt_q         <= '0;
            timeout_pulse <= 1'b1;
          end else begin
            watchdog <= watchdog + WDW'(1);
          end
        end
      endcase
    end
  end

endmodule
